// File: rtl/clock_div_pkg.sv
// Shared constants, per-channel control record and write-decode helper for the
// multi-channel clock divider.
package clock_div_pkg;

   localparam int CHAN_IDX_W   = 4;
   localparam int DIV_HALT     = 0;
   localparam int MAX_CHANNELS = 16;

   // Single-bit per-channel state. The SIZE-wide counter and divisors live in
   // the channel itself because their width is a module parameter.
   typedef struct packed {
      logic pend;
      logic clk_q;
      logic tick_q;
   } chan_ctrl_t;

   function automatic logic write_hit(input logic en,
                                      input logic [CHAN_IDX_W-1:0] idx,
                                      input int chan);
      return en && (int'(idx) == chan);
   endfunction

endpackage

// File: rtl/clock_div_multi_if.sv
// Divisor write bus, restart strobe and per-channel outputs of clock_div_multi.
interface clock_div_multi_if
   import clock_div_pkg::*;
#(
   parameter int CHANNELS = 4,
   parameter int SIZE     = 16
);

   logic                  wr_en;
   logic [CHAN_IDX_W-1:0] wr_chan;
   logic [SIZE-1:0]       wr_div;
   logic                  sync_restart;
   logic [CHANNELS-1:0]   clk_out;
   logic [CHANNELS-1:0]   tick;
   logic [CHANNELS-1:0]   pending;

   modport master (
      output wr_en, wr_chan, wr_div, sync_restart,
      input  clk_out, tick, pending
   );

   modport slave (
      input  wr_en, wr_chan, wr_div, sync_restart,
      output clk_out, tick, pending
   );

endinterface

// File: rtl/clock_div_chan.sv
// One divider channel: counter, active and pending divisors, and swap-at-terminal-count
// logic so divisor changes never produce a runt clock phase.
module clock_div_chan
   import clock_div_pkg::*;
#(
   parameter int SIZE        = 16,
   parameter int DIV_DEFAULT = 1
) (
   input  logic            clk_in,
   input  logic            reset,
   input  logic            gate,
   input  logic            wr_hit,
   input  logic [SIZE-1:0] wr_div,
   input  logic            sync_restart,
   output logic            clk_out,
   output logic            tick,
   output logic            pending
);

   logic [SIZE-1:0] cnt_q,  cnt_d;
   logic [SIZE-1:0] div_q,  div_d;
   logic [SIZE-1:0] nxt_q,  nxt_d;
   chan_ctrl_t      ctl_q,  ctl_d;
   logic            halted;
   logic            terminal;

   assign halted   = (div_q == SIZE'(DIV_HALT));
   assign terminal = !halted && (cnt_q == div_q - 1'b1);

   always_comb begin
      cnt_d        = cnt_q;
      div_d        = div_q;
      nxt_d        = nxt_q;
      ctl_d        = ctl_q;
      ctl_d.tick_q = 1'b0;

      if (sync_restart) begin
         // A write in the restart cycle beats any older pending value.
         cnt_d       = '0;
         ctl_d.clk_q = 1'b0;
         ctl_d.pend  = 1'b0;
         if (wr_hit) begin
            div_d = wr_div;
         end else if (ctl_q.pend) begin
            div_d = nxt_q;
         end
      end else if (halted) begin
         cnt_d       = '0;
         ctl_d.clk_q = 1'b0;
         if (wr_hit) begin
            div_d = wr_div;
         end
      end else begin
         if (wr_hit) begin
            nxt_d      = wr_div;
            ctl_d.pend = 1'b1;
         end
         if (gate) begin
            if (terminal) begin
               cnt_d        = '0;
               ctl_d.tick_q = 1'b1;
               ctl_d.clk_q  = ~ctl_q.clk_q;
               if (ctl_q.pend) begin
                  div_d      = nxt_q;
                  ctl_d.pend = wr_hit;
                  // Swapping in a halt parks the output low instead of toggling.
                  if (nxt_q == SIZE'(DIV_HALT)) begin
                     ctl_d.clk_q = 1'b0;
                  end
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (reset) begin
         cnt_q <= '0;
         div_q <= SIZE'(DIV_DEFAULT);
         nxt_q <= '0;
         ctl_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         div_q <= div_d;
         nxt_q <= nxt_d;
         ctl_q <= ctl_d;
      end
   end

   assign clk_out = ctl_q.clk_q;
   assign tick    = ctl_q.tick_q;
   assign pending = ctl_q.pend;

endmodule

// File: rtl/clock_div_multi.sv
// Multi-channel programmable clock divider with per-channel tick strobes.
// Optional feature: define CLK_DIV_GATE_EN to add a per-channel run gate input.
module clock_div_multi
   import clock_div_pkg::*;
#(
   parameter int CHANNELS    = 4,
   parameter int SIZE        = 16,
   parameter int DIV_DEFAULT = 1
) (
   input  logic                clk_in,
   input  logic                reset,
`ifdef CLK_DIV_GATE_EN
   input  logic [CHANNELS-1:0] gate,
`endif
   clock_div_multi_if.slave    bus
);

   localparam int NUM_CH = (CHANNELS > MAX_CHANNELS) ? MAX_CHANNELS : CHANNELS;

   logic [CHANNELS-1:0] clk_vec;
   logic [CHANNELS-1:0] tick_vec;
   logic [CHANNELS-1:0] pend_vec;

   // Out-of-range wr_chan matches no channel, so such writes are dropped here.
   for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
      logic ch_gate;
      logic ch_wr;

`ifdef CLK_DIV_GATE_EN
      assign ch_gate = gate[i];
`else
      assign ch_gate = 1'b1;
`endif
      assign ch_wr = write_hit(bus.wr_en, bus.wr_chan, i);

      clock_div_chan #(
         .SIZE        (SIZE),
         .DIV_DEFAULT (DIV_DEFAULT)
      ) u_chan (
         .clk_in       (clk_in),
         .reset        (reset),
         .gate         (ch_gate),
         .wr_hit       (ch_wr),
         .wr_div       (bus.wr_div),
         .sync_restart (bus.sync_restart),
         .clk_out      (clk_vec[i]),
         .tick         (tick_vec[i]),
         .pending      (pend_vec[i])
      );
   end

   if (NUM_CH < CHANNELS) begin : g_unused
      assign clk_vec[CHANNELS-1:NUM_CH]  = '0;
      assign tick_vec[CHANNELS-1:NUM_CH] = '0;
      assign pend_vec[CHANNELS-1:NUM_CH] = '0;
   end

   assign bus.clk_out = clk_vec;
   assign bus.tick    = tick_vec;
   assign bus.pending = pend_vec;

endmodule

// File: tb/tb_clock_div_multi.sv
// Self-checking bench for clock_div_multi: vector table, restart pattern sweep and
// mid-period reset, with expected outputs queued and compared after each clock edge.
module tb_clock_div_multi;

   localparam int CHANNELS = 4;
   localparam int SIZE     = 16;

   typedef struct {
      logic        rst;
      logic        we;
      logic [3:0]  ch;
      logic [15:0] dv;
      logic        rs;
      logic [3:0]  ec;
      logic [3:0]  et;
      logic [3:0]  ep;
   } vec_t;

   typedef struct {
      logic [3:0] ec;
      logic [3:0] et;
      logic [3:0] ep;
      string      tag;
   } exp_t;

   logic clk_in = 1'b0;
   logic reset;
   vec_t vecs[$];
   exp_t sbQueue[$];
   int   numCompared   = 0;
   int   numMismatched = 0;

   always #5 clk_in = ~clk_in;

   clock_div_multi_if #(.CHANNELS(CHANNELS), .SIZE(SIZE)) bus ();

`ifdef CLK_DIV_GATE_EN
   logic [CHANNELS-1:0] gate = '1;
`endif

   clock_div_multi #(
      .CHANNELS    (CHANNELS),
      .SIZE        (SIZE),
      .DIV_DEFAULT (1)
   ) dut (
      .clk_in (clk_in),
      .reset  (reset),
`ifdef CLK_DIV_GATE_EN
      .gate   (gate),
`endif
      .bus    (bus)
   );

   task automatic compareField(input string tag, input string field,
                               input logic [3:0] act, input logic [3:0] req);
      numCompared++;
      if (act !== req) begin
         numMismatched++;
         $display("[TB] FAIL %s.%s: actual=%b required=%b", tag, field, act, req);
      end
   endtask

   task automatic checkOutput();
      exp_t e;
      if (sbQueue.size() == 0) begin
         numCompared++;
         numMismatched++;
         $display("[TB] FAIL scoreboard: actual=empty required=entry");
      end else begin
         e = sbQueue.pop_front();
         compareField(e.tag, "clk_out", bus.clk_out, e.ec);
         compareField(e.tag, "tick",    bus.tick,    e.et);
         compareField(e.tag, "pending", bus.pending, e.ep);
      end
   endtask

   task automatic applyStimulus(input logic r, input logic we, input logic [3:0] ch,
                                input logic [15:0] dv, input logic rs,
                                input logic [3:0] ec, input logic [3:0] et,
                                input logic [3:0] ep, input string tag);
      exp_t e;
      reset            = r;
      bus.wr_en        = we;
      bus.wr_chan      = ch;
      bus.wr_div       = dv;
      bus.sync_restart = rs;
      e.ec  = ec;
      e.et  = et;
      e.ep  = ep;
      e.tag = tag;
      sbQueue.push_back(e);
      @(posedge clk_in);
      #1;
      checkOutput();
   endtask

   task automatic addVec(input logic r, input logic we, input logic [3:0] ch,
                         input logic [15:0] dv, input logic rs,
                         input logic [3:0] ec, input logic [3:0] et, input logic [3:0] ep);
      vec_t v;
      v.rst = r;  v.we = we; v.ch = ch; v.dv = dv; v.rs = rs;
      v.ec  = ec; v.et = et; v.ep = ep;
      vecs.push_back(v);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int          divs [4];
      logic        we;
      logic [3:0]  ch;
      logic [15:0] dv;
      logic [3:0]  ec, et, ep;
      int          j;

      reset            = 1'b1;
      bus.wr_en        = 1'b0;
      bus.wr_chan      = '0;
      bus.wr_div       = '0;
      bus.sync_restart = 1'b0;

      //     rst  we  ch     dv      rs   clk_out  tick     pending
      addVec(1, 0, 4'd0,  16'd0, 0, 4'b0000, 4'b0000, 4'b0000);
      addVec(1, 0, 4'd0,  16'd0, 0, 4'b0000, 4'b0000, 4'b0000);
      addVec(0, 0, 4'd0,  16'd0, 0, 4'b1111, 4'b1111, 4'b0000);
      addVec(0, 0, 4'd0,  16'd0, 0, 4'b0000, 4'b1111, 4'b0000);
      addVec(0, 1, 4'd1,  16'd3, 0, 4'b1111, 4'b1111, 4'b0010);
      addVec(0, 0, 4'd0,  16'd0, 0, 4'b0000, 4'b1111, 4'b0000);
      addVec(0, 0, 4'd0,  16'd0, 0, 4'b1101, 4'b1101, 4'b0000);
      addVec(0, 0, 4'd0,  16'd0, 0, 4'b0000, 4'b1101, 4'b0000);
      addVec(0, 0, 4'd0,  16'd0, 0, 4'b1111, 4'b1111, 4'b0000);
      addVec(0, 0, 4'd0,  16'd0, 0, 4'b0010, 4'b1101, 4'b0000);
      addVec(0, 0, 4'd0,  16'd0, 0, 4'b1111, 4'b1101, 4'b0000);
      addVec(0, 0, 4'd0,  16'd0, 0, 4'b0000, 4'b1111, 4'b0000);
      addVec(0, 1, 4'd2,  16'd5, 0, 4'b1101, 4'b1101, 4'b0100);
      addVec(0, 0, 4'd0,  16'd0, 0, 4'b0000, 4'b1101, 4'b0000);
      addVec(0, 0, 4'd0,  16'd0, 0, 4'b1011, 4'b1011, 4'b0000);
      addVec(0, 1, 4'd2,  16'd0, 0, 4'b0010, 4'b1001, 4'b0100);
      addVec(0, 0, 4'd0,  16'd0, 0, 4'b1011, 4'b1001, 4'b0100);
      addVec(0, 0, 4'd0,  16'd0, 0, 4'b0000, 4'b1011, 4'b0100);
      addVec(0, 0, 4'd0,  16'd0, 0, 4'b1001, 4'b1101, 4'b0000);
      addVec(0, 0, 4'd0,  16'd0, 0, 4'b0000, 4'b1001, 4'b0000);
      addVec(0, 0, 4'd0,  16'd0, 0, 4'b1011, 4'b1011, 4'b0000);
      addVec(0, 1, 4'd4,  16'd9, 0, 4'b0010, 4'b1001, 4'b0000);
      addVec(0, 1, 4'd15, 16'd9, 0, 4'b1011, 4'b1001, 4'b0000);
      addVec(0, 1, 4'd0,  16'd3, 0, 4'b0000, 4'b1011, 4'b0001);
      addVec(0, 1, 4'd3,  16'd7, 0, 4'b1001, 4'b1001, 4'b1000);
      addVec(0, 1, 4'd1,  16'd9, 0, 4'b0001, 4'b1000, 4'b0010);
      addVec(0, 1, 4'd1,  16'd4, 1, 4'b0000, 4'b0000, 4'b0000);

      $display("[TB] applying %0d table vectors", vecs.size());
      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].rst, vecs[i].we, vecs[i].ch, vecs[i].dv, vecs[i].rs,
                       vecs[i].ec, vecs[i].et, vecs[i].ep, $sformatf("vec%0d", i));
      end

      // After the restart: ch0=3, ch1=4, ch2 halted, ch3=7, all phase-aligned.
      // ch2 gets a halted-channel write of 2 at k=15; ch3 gets a pending 5 at k=22.
      divs[0] = 3;
      divs[1] = 4;
      divs[2] = 0;
      divs[3] = 7;
      for (int k = 1; k <= 22; k++) begin
         we = 1'b0;
         ch = 4'd0;
         dv = 16'd0;
         ec = 4'b0000;
         et = 4'b0000;
         ep = 4'b0000;
         if (k == 15) begin
            we = 1'b1; ch = 4'd2; dv = 16'd2;
         end
         if (k == 22) begin
            we = 1'b1; ch = 4'd3; dv = 16'd5;
            ep = 4'b1000;
         end
         for (int c = 0; c < 4; c++) begin
            if (c == 2) begin
               j = k - 15;
               if (j >= 0) begin
                  et[c] = (j > 0) && (j % 2 == 0);
                  ec[c] = ((j / 2) % 2) == 1;
               end
            end else begin
               et[c] = (k % divs[c]) == 0;
               ec[c] = ((k / divs[c]) % 2) == 1;
            end
         end
         applyStimulus(0, we, ch, dv, 0, ec, et, ep, $sformatf("restart_k%0d", k));
      end

      // Reset with ch3 pending: everything clears and divisors return to 1.
      applyStimulus(1, 0, 4'd0, 16'd0, 0, 4'b0000, 4'b0000, 4'b0000, "reset_mid");
      applyStimulus(0, 0, 4'd0, 16'd0, 0, 4'b1111, 4'b1111, 4'b0000, "post_reset1");
      applyStimulus(0, 0, 4'd0, 16'd0, 0, 4'b0000, 4'b1111, 4'b0000, "post_reset2");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
      $finish;
   end

endmodule
